// File: rtl/filter_pkg.sv
// Shared types and constants for the time-multiplexed biquad filter scheduler.
package filter_pkg;

    localparam int W        = 16;
    localparam int NUM_COEF = 6;

    typedef enum logic [2:0] {
        C_A0 = 3'd0,
        C_A1 = 3'd1,
        C_A2 = 3'd2,
        C_B0 = 3'd3,
        C_B1 = 3'd4,
        C_B2 = 3'd5
    } coef_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE,
        WRITE
    } state_t;

endpackage

// File: rtl/filter_scheduler_if.sv
// Control, sample, coefficient-write and result signals of the filter scheduler.
interface filter_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int W      = filter_pkg::W
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                       Enable;
    logic                       sample_tick;
    logic [NUM_CH-1:0][W-1:0]   x_in;
    logic                       coef_we;
    logic [CW-1:0]              coef_ch;
    logic [2:0]                 coef_idx;
    logic [W-1:0]               coef_data;
    logic                       clear_ovr;
    logic [W-1:0]               y_out;
    logic [CW-1:0]              y_ch;
    logic                       y_valid;
    logic                       busy;
    logic                       overrun;

    modport slave (
        input  Enable, sample_tick, x_in, coef_we, coef_ch, coef_idx, coef_data, clear_ovr,
        output y_out, y_ch, y_valid, busy, overrun
    );

    modport master (
        output Enable, sample_tick, x_in, coef_we, coef_ch, coef_idx, coef_data, clear_ovr,
        input  y_out, y_ch, y_valid, busy, overrun
    );

endinterface

// File: rtl/filter_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, a frame start
// commits the shadow bank (including a same-cycle write) into the active bank.
module filter_coef_bank #(
    parameter int NUM_CH = 4,
    parameter int W      = filter_pkg::W,
    parameter int CW     = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  we,
    input  logic [CW-1:0]         wr_ch,
    input  logic [2:0]            wr_idx,
    input  logic [W-1:0]          wr_data,
    input  logic                  commit,
    input  logic [CW-1:0]         rd_ch,
    input  filter_pkg::coef_idx_t rd_idx,
    output logic [W-1:0]          rd_data
);
    import filter_pkg::*;

    logic [W-1:0] shadow     [NUM_CH][NUM_COEF];
    logic [W-1:0] active     [NUM_CH][NUM_COEF];
    logic [W-1:0] shadowNext [NUM_CH][NUM_COEF];

    // Index values 6 and 7 match no slot, so those writes fall away here.
    always_comb begin
        shadowNext = shadow;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                if (we && wr_ch == CW'(c) && wr_idx == 3'(k)) begin
                    shadowNext[c][k] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NUM_COEF; k++) begin
                    shadow[c][k] <= '0;
                    active[c][k] <= '0;
                end
            end
        end else begin
            shadow <= shadowNext;
            if (commit) begin
                active <= shadowNext;
            end
        end
    end

    assign rd_data = active[rd_ch][rd_idx];

endmodule

// File: rtl/filter_scheduler.sv
// Serves NUM_CH biquad channels with one shared W x W multiplier,
// 7 cycles per channel: 5 MAC steps, one a0 scaling step and a history write-back.
module filter_scheduler #(
    parameter int NUM_CH = 4,
    parameter int W      = filter_pkg::W
) (
    input logic                Clk,
    input logic                Reset,
    filter_scheduler_if.slave  bus
);
    import filter_pkg::*;

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t        state, nextState;
    logic [CW-1:0] ch;
    logic [2:0]    step;
    logic [W-1:0]  xCur [NUM_CH];
    logic [W-1:0]  x1   [NUM_CH];
    logic [W-1:0]  x2   [NUM_CH];
    logic [W-1:0]  y1   [NUM_CH];
    logic [W-1:0]  y2   [NUM_CH];
    logic [W-1:0]  acc, yScaled, yOut;
    logic [CW-1:0] yCh;
    logic          yValid, overrun, busy;
    logic          accept, drop, lastStep, lastCh;
    coef_idx_t     coefSel;
    logic [W-1:0]  coefVal, operand, productHi;
    logic [2*W-1:0] mulAx, mulBx;

    assign accept   = (state == IDLE) && bus.Enable && bus.sample_tick;
    assign drop     = (state != IDLE) && bus.sample_tick;
    assign lastStep = (step == 3'd4);
    assign lastCh   = (ch == CW'(NUM_CH - 1));

    filter_coef_bank #(.NUM_CH(NUM_CH), .W(W), .CW(CW)) coefBank (
        .Clk     (Clk),
        .Reset   (Reset),
        .we      (bus.coef_we),
        .wr_ch   (bus.coef_ch),
        .wr_idx  (bus.coef_idx),
        .wr_data (bus.coef_data),
        .commit  (accept),
        .rd_ch   (ch),
        .rd_idx  (coefSel),
        .rd_data (coefVal)
    );

    // The single multiplier: sign-extended operands, keep the upper W product bits.
    assign mulAx     = {{W{coefVal[W-1]}}, coefVal};
    assign mulBx     = {{W{operand[W-1]}}, operand};
    assign productHi = W'((mulAx * mulBx) >> W);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept) nextState = MAC;
            MAC:     if (lastStep) nextState = SCALE;
            SCALE:   nextState = WRITE;
            WRITE:   nextState = lastCh ? IDLE : MAC;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        coefSel = C_A0;
        operand = acc;
        if (state == MAC) begin
            unique case (step)
                3'd0:    begin coefSel = C_B0; operand = xCur[ch]; end
                3'd1:    begin coefSel = C_B1; operand = x1[ch];   end
                3'd2:    begin coefSel = C_B2; operand = x2[ch];   end
                3'd3:    begin coefSel = C_A1; operand = y1[ch];   end
                default: begin coefSel = C_A2; operand = y2[ch];   end
            endcase
        end
    end

    // History feeds back the unscaled accumulator; y_out carries the a0-scaled value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ch      <= '0;
            step    <= '0;
            acc     <= '0;
            yScaled <= '0;
            yOut    <= '0;
            yCh     <= '0;
            yValid  <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                xCur[i] <= '0;
                x1[i]   <= '0;
                x2[i]   <= '0;
                y1[i]   <= '0;
                y2[i]   <= '0;
            end
        end else begin
            yValid <= 1'b0;
            if (drop) begin
                overrun <= 1'b1;
            end else if (bus.clear_ovr) begin
                overrun <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            xCur[i] <= bus.x_in[i];
                        end
                        ch   <= '0;
                        step <= '0;
                    end
                end
                MAC: begin
                    acc  <= ((step == 3'd0) ? '0 : acc) + productHi;
                    step <= step + 3'd1;
                end
                SCALE: begin
                    yScaled <= productHi;
                end
                WRITE: begin
                    x2[ch] <= x1[ch];
                    x1[ch] <= xCur[ch];
                    y2[ch] <= y1[ch];
                    y1[ch] <= acc;
                    yOut   <= yScaled;
                    yCh    <= ch;
                    yValid <= 1'b1;
                    ch     <= ch + 1'b1;
                    step   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.y_out   = yOut;
    assign bus.y_ch    = yCh;
    assign bus.y_valid = yValid;
    assign bus.busy    = busy;
    assign bus.overrun = overrun;

endmodule

// File: tb/tb_filter_scheduler.sv
// Directed bench for filter_scheduler: hand-computed outputs, frame timing, overrun,
// shadow coefficient commit and mid-frame reset.
module tb_filter_scheduler;
    import filter_pkg::*;

    localparam int NCH = 4;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   hookAt = 0;
    int   hookKind = 0;
    logic [W-1:0] hookData = '0;

    always #5 Clk = ~Clk;

    filter_scheduler_if #(.NUM_CH(NCH), .W(W)) bus ();

    filter_scheduler #(.NUM_CH(NCH), .W(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic stepClk();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeCoef(input int ch, input coef_idx_t idx, input logic [W-1:0] data);
        bus.coef_we   = 1'b1;
        bus.coef_ch   = 2'(ch);
        bus.coef_idx  = idx;
        bus.coef_data = data;
        stepClk();
        bus.coef_we   = 1'b0;
    endtask

    // One-cycle tick on ch0 input; optionally a same-cycle a0 write to ch0.
    task automatic applyStimulus(input logic [W-1:0] x0, input logic wrA0, input logic [W-1:0] a0Data);
        bus.x_in        = '0;
        bus.x_in[0]     = x0;
        bus.sample_tick = 1'b1;
        if (wrA0) begin
            bus.coef_we   = 1'b1;
            bus.coef_ch   = '0;
            bus.coef_idx  = C_A0;
            bus.coef_data = a0Data;
        end
        stepClk();
        bus.sample_tick = 1'b0;
        bus.coef_we     = 1'b0;
        bus.x_in        = {NCH{16'h7777}};
    endtask

    // Walks the 28 cycles after the accepting edge; hookKind 1=tick, 2=b0 write, 3=reset at hookAt.
    task automatic checkFrame(input string tag, input logic [W-1:0] expY0);
        logic aborted, expValid;
        checkOutput({tag, ".busy0"}, 32'(bus.busy), 32'd1);
        for (int n = 1; n <= 28; n++) begin
            bus.sample_tick = (hookKind == 1 && n == hookAt);
            Reset           = (hookKind == 3 && n == hookAt);
            if (hookKind == 2 && n == hookAt) begin
                bus.coef_we   = 1'b1;
                bus.coef_ch   = '0;
                bus.coef_idx  = C_B0;
                bus.coef_data = hookData;
            end
            stepClk();
            bus.sample_tick = 1'b0;
            Reset           = 1'b0;
            bus.coef_we     = 1'b0;
            aborted  = (hookKind == 3 && n >= hookAt);
            expValid = !aborted && (n % 7 == 0);
            checkOutput($sformatf("%s.valid@%0d", tag, n), 32'(bus.y_valid), 32'(expValid));
            checkOutput($sformatf("%s.busy@%0d", tag, n), 32'(bus.busy), 32'(!aborted && n < 28));
            if (expValid) begin
                checkOutput($sformatf("%s.ych@%0d", tag, n), 32'(bus.y_ch), 32'(n / 7 - 1));
                checkOutput($sformatf("%s.yout@%0d", tag, n), 32'(bus.y_out), (n == 7) ? 32'(expY0) : 32'd0);
            end
            if (aborted) begin
                checkOutput($sformatf("%s.rstyout@%0d", tag, n), 32'(bus.y_out), 32'd0);
                checkOutput($sformatf("%s.rstych@%0d", tag, n), 32'(bus.y_ch), 32'd0);
                checkOutput($sformatf("%s.rstovr@%0d", tag, n), 32'(bus.overrun), 32'd0);
            end
            if (hookKind == 1) begin
                checkOutput($sformatf("%s.ovr@%0d", tag, n), 32'(bus.overrun), 32'(n >= hookAt));
            end
        end
        hookKind = 0;
    endtask

    initial begin
        Reset           = 1'b1;
        bus.Enable      = 1'b0;
        bus.sample_tick = 1'b0;
        bus.x_in        = '0;
        bus.coef_we     = 1'b0;
        bus.coef_ch     = '0;
        bus.coef_idx    = '0;
        bus.coef_data   = '0;
        bus.clear_ovr   = 1'b0;
        repeat (3) stepClk();
        checkOutput("reset.yout", 32'(bus.y_out), 32'd0);
        checkOutput("reset.ych", 32'(bus.y_ch), 32'd0);
        checkOutput("reset.valid", 32'(bus.y_valid), 32'd0);
        checkOutput("reset.busy", 32'(bus.busy), 32'd0);
        checkOutput("reset.ovr", 32'(bus.overrun), 32'd0);
        Reset = 1'b0;

        // Tick while Enable is low is neither accepted nor an overrun.
        bus.sample_tick = 1'b1;
        stepClk();
        bus.sample_tick = 1'b0;
        checkOutput("disabled.busy", 32'(bus.busy), 32'd0);
        checkOutput("disabled.ovr", 32'(bus.overrun), 32'd0);
        bus.Enable = 1'b1;

        writeCoef(0, C_B0, 16'h4000);
        writeCoef(0, C_A0, 16'h7FFF);
        applyStimulus(16'h4000, 1'b0, '0);
        checkFrame("single", 16'h07FF);

        writeCoef(0, C_A1, 16'h4000);
        applyStimulus(16'h0000, 1'b0, '0);
        bus.Enable = 1'b0;
        checkFrame("recur", 16'h01FF);
        bus.Enable = 1'b1;

        hookKind = 1;
        hookAt   = 10;
        applyStimulus(16'h0000, 1'b0, '0);
        checkFrame("ovr", 16'h007F);
        stepClk();
        checkOutput("ovr.idlebusy", 32'(bus.busy), 32'd0);
        checkOutput("ovr.idlevalid", 32'(bus.y_valid), 32'd0);
        checkOutput("ovr.sticky", 32'(bus.overrun), 32'd1);
        bus.clear_ovr = 1'b1;
        stepClk();
        bus.clear_ovr = 1'b0;
        checkOutput("ovr.cleared", 32'(bus.overrun), 32'd0);

        hookKind = 2;
        hookAt   = 3;
        hookData = 16'h2000;
        applyStimulus(16'h4000, 1'b0, '0);
        checkFrame("shadow", 16'h081F);
        applyStimulus(16'h4000, 1'b0, '0);
        checkFrame("commit", 16'h0607);

        hookKind = 3;
        hookAt   = 9;
        applyStimulus(16'h4000, 1'b0, '0);
        checkFrame("rst", 16'h0581);

        writeCoef(0, C_B0, 16'h4000);
        writeCoef(0, C_A1, 16'h4000);
        applyStimulus(16'h4000, 1'b1, 16'h7FFF);
        checkFrame("fresh", 16'h07FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_scheduler.md
FILTER_SCHEDULER -- requirements
Module: filter_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent biquad channels served by the one shared multiplier.
REQ-002 SHALL have parameter W, default 16, meaning the sample and coefficient width (signed).
REQ-003 SHALL have port Clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset  in  1  meaning reset; reset is synchronous and active-high.
REQ-005 SHALL have port Enable  in  1  meaning sample_tick is accepted only while high.
REQ-006 SHALL have port sample_tick  in  1  meaning start-of-frame strobe, one cycle wide.
REQ-007 SHALL have port x_in  in  NUM_CH x W signed  meaning the per-channel input samples, captured on an accepted tick.
REQ-008 SHALL have port coef_we  in  1  meaning write strobe into the shadow coefficient bank.
REQ-009 SHALL have port coef_ch  in  clog2(NUM_CH)  meaning the target channel of a coefficient write.
REQ-010 SHALL have port coef_idx  in  3  meaning the coefficient select: 0=a0, 1=a1, 2=a2, 3=b0, 4=b1, 5=b2; values 6-7 are ignored.
REQ-011 SHALL have port coef_data  in  W signed  meaning the coefficient value.
REQ-012 SHALL have port clear_ovr  in  1  meaning clear the overrun flag.
REQ-013 SHALL have port y_out  out  W signed  meaning the filtered result.
REQ-014 SHALL have port y_ch  out  clog2(NUM_CH)  meaning the channel of y_out.
REQ-015 SHALL have port y_valid  out  1  meaning y_out/y_ch are valid this cycle.
REQ-016 SHALL have port busy  out  1  meaning a frame is in progress.
REQ-017 SHALL have port overrun  out  1  meaning sticky: a tick was dropped.

Function
REQ-018 SHALL accept a tick only in state IDLE with Enable=1; on acceptance it SHALL latch x_in, copy the shadow bank into the active bank, set ch=0 and step=0, and enter MAC.
REQ-019 SHALL, in MAC, perform one product per cycle in the order b0*x, b1*x1, b2*x2, a1*y1, a2*y2 (steps 0-4), using the per-channel history.
REQ-020 SHALL form each product as a 2W-bit signed value and add only bits [2W-1:W] into a W-bit accumulator that wraps in two's complement (no saturation); the accumulator is cleared at step 0.
REQ-021 SHALL, in SCALE (1 cycle), compute y = (a0*acc)[2W-1:W] using the same multiplier.
REQ-022 SHALL, in WRITE (1 cycle), shift the history (x2<=x1, x1<=x, y2<=y1, y1<=acc), register y_out/y_ch, and pulse y_valid on the following cycle for exactly one cycle.
REQ-023 SHALL advance ch after WRITE and return to MAC; after channel NUM_CH-1 it SHALL return to IDLE, giving 7 cycles per channel.
REQ-024 SHALL assert y_valid for channel c on cycle 7*(c+1) after the accepting edge.
REQ-025 SHALL drive busy high in every state other than IDLE.
REQ-026 SHALL ignore a tick while busy and set overrun; overrun stays set until clear_ovr or Reset; if a drop and clear_ovr occur in the same cycle, overrun SHALL end up set.
REQ-027 SHALL accept coefficient writes in any cycle into the shadow bank only; an in-progress frame uses the active bank unchanged.
REQ-028 SHALL, when a coefficient write and an accepted tick occur in the same cycle, include the written value in the copy to the active bank.
REQ-029 SHALL let a frame in progress complete when Enable falls mid-frame.

Reset
REQ-030 SHALL, on Reset, enter IDLE and clear both coefficient banks, all history, the accumulator, y_out, y_ch, y_valid, busy, and overrun to 0.
REQ-031 SHALL, on Reset asserted mid-frame, abort the frame with no further y_valid pulses.

Structure
REQ-032 SHALL define W, the coefficient index enum, and the state enum (IDLE, MAC, SCALE, WRITE) in the shared package filter_pkg.
REQ-033 SHALL place the shadow/active coefficient storage in the sub-module filter_coef_bank.
REQ-034 SHALL instantiate exactly one W x W multiplier.

Verification
REQ-035 SHALL check single-product output: ch0 b0=0x4000, a0=0x7FFF, others 0; tick with x0=0x4000 -> y_valid at +7 with y_out=0x07FF and y_ch=0.
REQ-036 SHALL check recursion: as REQ-035 plus a1=0x4000; a second tick with x0=0 -> ch0 y_out=0x01FF.
REQ-037 SHALL check frame timing: NUM_CH=4 and one tick -> y_valid at +7, +14, +21, +28 with y_ch=0..3, and busy high for 28 cycles.
REQ-038 SHALL check overrun: a tick at +10 -> ignored, overrun=1, no extra outputs; then clear_ovr -> overrun=0.
REQ-039 SHALL check shadow commit: write b0 during a frame -> current outputs unchanged, new value used after the next tick.
REQ-040 SHALL check reset: Reset at +9 -> IDLE, all outputs 0, no y_valid; the next tick yields history-free results.
